// File: rtl/game_flow_ctl.sv
// rtl/game_flow_ctl.sv - round sequencer for the flappy-rect game
//
// Owns the frame tick and the round state machine (IDLE, COUNTDOWN, PLAY,
// DYING, OVER), gates the bird position controller, gates flap input,
// counts the score and keeps the best finished-round score.
//
// Optional build macro: PAUSE_EN adds pause_btn and the PAUSED state.
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   start_btn     start/restart button level (synchronised)
//   flap_btn      flap button level (synchronised)
//   pause_btn     pause button level (synchronised, PAUSE_EN only)
//   bird_ypos     bird top y from the position controller
//   pipe_passed   one-cycle pulse when a pipe is cleared
//   collision     level from the obstacle hit detector
//   tick          one-cycle frame strobe
//   phys_en       enable for the bird position controller (PLAY only)
//   phys_rst      one-cycle pulse returning the bird to its start position
//   flap_pulse    one-cycle flap request (PLAY only)
//   state_o       current state encoding
//   score         current round score (saturating)
//   best_score    highest finished-round score since reset
//   endgame       high while in OVER
module game_flow_ctl #(
  parameter int TICK_CYCLES     = 4_000_000,
  parameter int COUNTDOWN_TICKS = 3,
  parameter int DYING_TICKS     = 2,
  parameter int VER_PIXELS      = 600,
  parameter int BIRD_H          = 20,
  parameter int SCORE_W         = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_btn,
  input  logic               flap_btn,
`ifdef PAUSE_EN
  input  logic               pause_btn,
`endif
  input  logic [11:0]        bird_ypos,
  input  logic               pipe_passed,
  input  logic               collision,
  output logic               tick,
  output logic               phys_en,
  output logic               phys_rst,
  output logic               flap_pulse,
  output logic [2:0]         state_o,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] best_score,
  output logic               endgame
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_COUNTDOWN = 3'd1;
  localparam logic [2:0] ST_PLAY      = 3'd2;
  localparam logic [2:0] ST_DYING     = 3'd3;
  localparam logic [2:0] ST_OVER      = 3'd4;
`ifdef PAUSE_EN
  localparam logic [2:0] ST_PAUSED    = 3'd5;
`endif

  localparam int TC_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int CD_W = $clog2(COUNTDOWN_TICKS + 1);
  localparam int DC_W = $clog2(DYING_TICKS + 1);

  localparam logic [TC_W-1:0] TC_LAST = TC_W'(TICK_CYCLES - 1);
  localparam logic [CD_W-1:0] CD_INIT = CD_W'(COUNTDOWN_TICKS);
  localparam logic [DC_W-1:0] DC_INIT = DC_W'(DYING_TICKS);
  localparam logic [11:0]     DEATH_Y = 12'(VER_PIXELS - BIRD_H);

  logic [2:0]         state, state_next;
  logic [TC_W-1:0]    tick_cnt, tick_cnt_next;
  logic [CD_W-1:0]    cd, cd_next;
  logic [DC_W-1:0]    dc, dc_next;
  logic               start_prev, flap_prev;
  logic               start_rise, flap_rise;
  logic               death;
  logic               phys_en_next, phys_rst_next, flap_next, endgame_next;
  logic [SCORE_W-1:0] score_next, best_next;
`ifdef PAUSE_EN
  logic               pause_prev, pause_rise;
`endif

  assign start_rise = start_btn & ~start_prev;
  assign flap_rise  = flap_btn & ~flap_prev;
`ifdef PAUSE_EN
  assign pause_rise = pause_btn & ~pause_prev;
`endif
  assign death      = collision | (bird_ypos >= DEATH_Y);

  // tick is registered one cycle ahead so it is high exactly while the
  // counter holds TC_LAST
  assign tick_cnt_next = (tick_cnt == TC_LAST) ? '0 : tick_cnt + TC_W'(1);

  assign state_o = state;

  // State register and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      tick_cnt   <= '0;
      tick       <= 1'b0;
      cd         <= '0;
      dc         <= '0;
      start_prev <= 1'b1;
      flap_prev  <= 1'b1;
`ifdef PAUSE_EN
      pause_prev <= 1'b1;
`endif
      phys_en    <= 1'b0;
      phys_rst   <= 1'b0;
      flap_pulse <= 1'b0;
      endgame    <= 1'b0;
      score      <= '0;
      best_score <= '0;
    end else begin
      state      <= state_next;
      tick_cnt   <= tick_cnt_next;
      tick       <= (tick_cnt_next == TC_LAST);
      cd         <= cd_next;
      dc         <= dc_next;
      start_prev <= start_btn;
      flap_prev  <= flap_btn;
`ifdef PAUSE_EN
      pause_prev <= pause_btn;
`endif
      phys_en    <= phys_en_next;
      phys_rst   <= phys_rst_next;
      flap_pulse <= flap_next;
      endgame    <= endgame_next;
      score      <= score_next;
      best_score <= best_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    cd_next    = cd;
    dc_next    = dc;
    case (state)
      ST_IDLE, ST_OVER: begin
        if (start_rise) begin
          state_next = ST_COUNTDOWN;
          cd_next    = CD_INIT;
        end
      end
      ST_COUNTDOWN: begin
        if (tick) begin
          if (cd == CD_W'(1)) state_next = ST_PLAY;
          else                cd_next    = cd - CD_W'(1);
        end
      end
      ST_PLAY: begin
`ifdef PAUSE_EN
        if (pause_rise) begin
          state_next = ST_PAUSED;
        end else
`endif
        if (death) begin
          state_next = ST_DYING;
          dc_next    = DC_INIT;
        end
      end
      ST_DYING: begin
        if (tick) begin
          if (dc == DC_W'(1)) state_next = ST_OVER;
          else                dc_next    = dc - DC_W'(1);
        end
      end
`ifdef PAUSE_EN
      ST_PAUSED: begin
        if (pause_rise)      state_next = ST_PLAY;
        else if (start_rise) state_next = ST_IDLE;
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  // Output / datapath next values, registered alongside the state
  always_comb begin
    phys_en_next  = (state_next == ST_PLAY);
    endgame_next  = (state_next == ST_OVER);
    phys_rst_next = ((state == ST_IDLE) || (state == ST_OVER)) && start_rise;
    flap_next     = (state == ST_PLAY) && flap_rise;

    // A pipe cleared in the same cycle as death still counts
    score_next = score;
    if (phys_rst_next)
      score_next = '0;
    else if ((state == ST_PLAY) && pipe_passed && (score != {SCORE_W{1'b1}}))
      score_next = score + SCORE_W'(1);

    best_next = best_score;
    if ((state_next == ST_OVER) && (state != ST_OVER) && (score_next > best_score))
      best_next = score_next;
  end

endmodule

// File: doc/game_flow_ctl.md
Name: game_flow_ctl

Overview:
- Top-level game sequencer for the flappy-rect game.
- Owns the frame tick and the round state machine (idle, countdown, play, dying, over).
- Gates and resets the bird-position controller, gates flap input, counts score, keeps best score.
- Sits between the button synchronisers, the bird/obstacle datapath and the VGA overlay/score display.

Parameters:
TICK_CYCLES, 4_000_000, clk cycles per frame tick (tick period)
COUNTDOWN_TICKS, 3, ticks spent in COUNTDOWN before PLAY (>=1)
DYING_TICKS, 2, ticks spent in DYING before OVER (>=1)
VER_PIXELS, 600, visible screen height in pixels
BIRD_H, 20, bird sprite height in pixels
SCORE_W, 8, score counter width

Ports:
clk  input  1  system clock
rst  input  1  reset
start_btn  input  1  start/restart button, level, already synchronised
flap_btn  input  1  flap button, level, already synchronised
bird_ypos  input  12  bird top y from position controller
pipe_passed  input  1  one-cycle pulse from obstacle generator when a pipe is cleared
collision  input  1  level from obstacle hit detector
tick  output  1  one-cycle frame strobe
phys_en  output  1  enable for bird position controller
phys_rst  output  1  one-cycle pulse: bird position controller returns to start position
flap_pulse  output  1  one-cycle flap request to position controller
state_o  output  3  current state encoding
score  output  SCORE_W  current round score
best_score  output  SCORE_W  highest finished-round score since reset
endgame  output  1  high in OVER

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. All outputs 0, state IDLE, tick counter 0, countdown/dying counters 0, edge-detect registers 1 (a button held through reset produces no edge).
- Tick: free-running counter 0..TICK_CYCLES-1. tick=1 exactly in the cycle the counter equals TICK_CYCLES-1; counter then wraps to 0. Runs in every state.
- Edge detect: start_rise = start_btn & ~start_prev. flap_rise likewise. Both registered outputs are derived in the same cycle as the rising input sample.
- Encodings: IDLE=0, COUNTDOWN=1, PLAY=2, DYING=3, OVER=4. All outputs are registered. state_o equals the current state.
- IDLE:
  - On start_rise: go to COUNTDOWN, phys_rst=1 for one cycle, score<=0, cd<=COUNTDOWN_TICKS.
- COUNTDOWN:
  - phys_en=0.
  - On tick: if cd==1, go to PLAY; else cd<=cd-1.
  - start_rise is ignored.
- PLAY:
  - phys_en=1.
  - flap_pulse=1 one cycle per flap_rise. Flap edges in any other state are dropped.
  - pipe_passed: score<=score+1, saturating at all-ones.
  - Death condition: collision=1 or bird_ypos >= VER_PIXELS-BIRD_H. On death go to DYING, dc<=DYING_TICKS.
  - Simultaneous pipe_passed and death in the same cycle: score increments, then DYING.
- DYING:
  - phys_en=0. score frozen.
  - On tick: if dc==1, go to OVER; else dc<=dc-1.
- OVER:
  - endgame=1.
  - On entry, best_score<=score if score>best_score (one-cycle update).
  - On start_rise: same action as from IDLE (COUNTDOWN, phys_rst pulse, score cleared). endgame drops the same cycle.
- Unreachable encodings go to IDLE.
- rst asserted mid-round: immediate return to reset values. best_score is cleared too.

Optional Feature:
PAUSE_EN:
- Defined: adds input port pause_btn (1 bit, synchronised, edge-detected like the others, prev reset 1) and state PAUSED=5.
- PLAY + pause rise goes to PAUSED. phys_en=0. collision, bird_ypos, pipe_passed and flap are ignored.
- PAUSED + pause rise returns to PLAY.
- PAUSED + start_rise goes to IDLE with score kept.
- Undefined: no port, no state. Encoding 5 is unreachable and maps to IDLE.

Test Plan:
- TICK_CYCLES=10: rst then run 35 cycles -> tick pulses at cycles 9, 19, 29 after reset release; never two consecutive cycles high.
- start_btn held through reset, released, pressed -> only the second press gives phys_rst pulse and COUNTDOWN; PLAY entered on the 3rd tick after COUNTDOWN entry.
- In PLAY: 5 pipe_passed pulses, flap_btn toggled twice -> score=5, two one-cycle flap_pulse; flap toggled in COUNTDOWN gives no pulse.
- PLAY with bird_ypos=580 (VER_PIXELS-BIRD_H) -> DYING next cycle, phys_en=0; OVER after 2 ticks, endgame=1, best_score=5. Second round scoring 3 -> best_score stays 5.
- pipe_passed and collision in same cycle at score=255 (SCORE_W=8) -> score stays 255, state DYING.
- rst pulse while in PLAY with score=7, best=5 -> all outputs 0, state IDLE, best_score=0. With PAUSE_EN: pause press freezes phys_en=0 and collision is ignored; second press resumes PLAY.
